rgb_matrix_scan_ctrl: RTL and testbench

Scan and PWM scheduler for the 5×5 RGB LED matrix. It holds a double-buffered 25-pixel frame store with 4-bit R/G/B per pixel, accepts host pixel writes into the back bank, and multiplexes rows one at a time. It drives one-hot row enables and per-column R/G/B PWM bits. Banks swap only on frame boundaries, so the display never shows a partially written frame.

---
 rtl/rgb_matrix_scan_ctrl_if.sv | 21 ++
 rtl/rgb_matrix_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rgb_matrix_scan_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_matrix_scan_ctrl_if.sv
// Host-side handshake bundle for rgb_matrix_scan_ctrl: pixel writes into the
// back bank plus the bank-swap request/acknowledge pair.
interface rgb_matrix_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [11:0] wr_data;
    logic        wr_err;
    logic        swap_req;
    logic        swap_ack;

    modport master (
        output wr_valid, wr_addr, wr_data, swap_req,
        input  wr_ready, wr_err, swap_ack
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, swap_req,
        output wr_ready, wr_err, swap_ack
    );
endinterface

// File: rtl/rgb_matrix_scan_ctrl.sv
// Scan and PWM scheduler for a 5x5 RGB LED matrix with a double-buffered
// 25-pixel frame store (4-bit R/G/B per pixel). Rows are scanned one at a
// time; each row shows 16 PWM slots of PRESCALE clocks. Banks swap only on a
// frame boundary (or immediately while scanning is disabled).
// Optional feature: define RGB_SCAN_BLANK_EN to insert a PRESCALE-cycle
// blanking interval after every row (frame becomes 85*PRESCALE cycles).
module rgb_matrix_scan_ctrl #(
    parameter int unsigned PRESCALE = 256,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    rgb_matrix_scan_ctrl_if.slave   host_io,
    output logic                    frame_start_o,
    output logic [4:0]              row_o,
    output logic [4:0]              col_r_o,
    output logic [4:0]              col_g_o,
    output logic [4:0]              col_b_o
);

    localparam int unsigned         PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0]     PreMax  = PreW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] SlotMax = '1;
    localparam logic [2:0]          RowMax  = 3'd4;

    typedef enum logic [1:0] {StIdle, StScan, StBlank} state_e;

    state_e                state_q;
    logic [PreW-1:0]       pre_q;
    logic [PWM_BITS-1:0]   slot_q;
    logic [2:0]            rowidx_q;
    logic [2:0]            next_row;
    logic [4:0]            pix_base;

    logic                  front_sel_q;
    logic                  swap_pending_q, swap_pending_d;
    logic                  swap_now, frame_end, wr_acc;
    logic                  wr_ready_q, wr_err_q, swap_ack_q;

    logic                  frame_start_q;
    logic [4:0]            row_q, col_r_q, col_g_q, col_b_q;
    logic [4:0]            col_r_d, col_g_d, col_b_d;

    logic [11:0]           bank_q [2][25];

    assign next_row = (rowidx_q == RowMax) ? 3'd0 : rowidx_q + 3'd1;
    assign pix_base = {2'b00, rowidx_q} * 5'd5;
    assign wr_acc   = host_io.wr_valid && wr_ready_q;

    // Swap scheduling: frame boundary while scanning, next cycle while disabled.
    always_comb begin
`ifdef RGB_SCAN_BLANK_EN
        frame_end = (state_q == StBlank) && (rowidx_q == RowMax) && (pre_q == PreMax);
`else
        frame_end = (state_q == StScan) && (rowidx_q == RowMax) &&
                    (slot_q == SlotMax) && (pre_q == PreMax);
`endif
        swap_now = enable_i ? (swap_pending_q && frame_end)
                            : (swap_pending_q || host_io.swap_req);
        swap_pending_d = swap_now ? 1'b0 : (swap_pending_q || host_io.swap_req);
    end

    // PWM compare of the active row against the front bank.
    always_comb begin
        logic [11:0] pix;
        pix     = '0;
        col_r_d = '0;
        col_g_d = '0;
        col_b_d = '0;
        for (int c = 0; c < 5; c++) begin
            pix        = bank_q[front_sel_q][pix_base + 5'(c)];
            col_r_d[c] = slot_q < pix[11:8];
            col_g_d[c] = slot_q < pix[7:4];
            col_b_d[c] = slot_q < pix[3:0];
        end
    end

    // Frame store: host writes always target the bank not on display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 25; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (wr_acc && (host_io.wr_addr <= 5'd24)) begin
            bank_q[~front_sel_q][host_io.wr_addr] <= host_io.wr_data;
        end
    end

    // Handshake state: bank select, pending swap, ready/error/ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            wr_ready_q     <= 1'b0;
            wr_err_q       <= 1'b0;
            swap_ack_q     <= 1'b0;
        end else begin
            front_sel_q    <= front_sel_q ^ swap_now;
            swap_pending_q <= swap_pending_d;
            wr_ready_q     <= !swap_pending_d;
            wr_err_q       <= wr_acc && (host_io.wr_addr > 5'd24);
            swap_ack_q     <= swap_now;
        end
    end

    // Scan FSM with counters; outputs are registered from the current counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pre_q         <= '0;
            slot_q        <= '0;
            rowidx_q      <= '0;
            frame_start_q <= 1'b0;
            row_q         <= '0;
            col_r_q       <= '0;
            col_g_q       <= '0;
            col_b_q       <= '0;
        end else begin
            frame_start_q <= 1'b0;
            row_q         <= '0;
            col_r_q       <= '0;
            col_g_q       <= '0;
            col_b_q       <= '0;
            if (state_q == StScan) begin
                frame_start_q <= (rowidx_q == 3'd0) && (slot_q == '0) && (pre_q == '0);
                row_q         <= 5'b00001 << rowidx_q;
                col_r_q       <= col_r_d;
                col_g_q       <= col_g_d;
                col_b_q       <= col_b_d;
            end

            if (!enable_i) begin
                state_q  <= StIdle;
                pre_q    <= '0;
                slot_q   <= '0;
                rowidx_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StScan;
                    StScan: begin
                        if (pre_q != PreMax) begin
                            pre_q <= pre_q + PreW'(1);
                        end else begin
                            pre_q <= '0;
                            if (slot_q != SlotMax) begin
                                slot_q <= slot_q + PWM_BITS'(1);
                            end else begin
                                slot_q <= '0;
`ifdef RGB_SCAN_BLANK_EN
                                state_q <= StBlank;
`else
                                rowidx_q <= next_row;
`endif
                            end
                        end
                    end
`ifdef RGB_SCAN_BLANK_EN
                    StBlank: begin
                        if (pre_q != PreMax) begin
                            pre_q <= pre_q + PreW'(1);
                        end else begin
                            pre_q    <= '0;
                            rowidx_q <= next_row;
                            state_q  <= StScan;
                        end
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign host_io.wr_ready = wr_ready_q;
    assign host_io.wr_err   = wr_err_q;
    assign host_io.swap_ack = swap_ack_q;
    assign frame_start_o    = frame_start_q;
    assign row_o            = row_q;
    assign col_r_o          = col_r_q;
    assign col_g_o          = col_g_q;
    assign col_b_o          = col_b_q;

endmodule

// File: tb/tb_rgb_matrix_scan_ctrl.sv
// Self-checking bench for rgb_matrix_scan_ctrl with PRESCALE = 2. Expected
// display is derived from frame position (phase since frame_start) and a
// model of the two banks. Honours RGB_SCAN_BLANK_EN for row/frame length.
module tb_rgb_matrix_scan_ctrl;
    localparam int P = 2;
`ifdef RGB_SCAN_BLANK_EN
    localparam int RowLen = 17 * P;
`else
    localparam int RowLen = 16 * P;
`endif
    localparam int FL = 5 * RowLen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       frame_start;
    logic [4:0] row, col_r, col_g, col_b;

    rgb_matrix_scan_ctrl_if bus ();

    rgb_matrix_scan_ctrl #(.PRESCALE(P), .PWM_BITS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .host_io       (bus),
        .frame_start_o (frame_start),
        .row_o         (row),
        .col_r_o       (col_r),
        .col_g_o       (col_g),
        .col_b_o       (col_b)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] m_bank [2][25];
    int          m_front = 0;
    int          disp_front = 0;
    bit          m_pending = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 25; i++) m_bank[b][i] = '0;
        m_front = 0;
        disp_front = 0;
        m_pending = 1'b0;
    endtask

    // Expected {row, col_r, col_g, col_b} at phase p of a frame.
    function automatic logic [19:0] exp_disp(int p);
        logic [4:0]  rw, r, g, b;
        logic [11:0] px;
        int          ri, o, slot;
        rw = '0; r = '0; g = '0; b = '0;
        ri = p / RowLen;
        o  = p % RowLen;
        if (o < 16 * P) begin
            slot = o / P;
            rw   = 5'(1 << ri);
            for (int c = 0; c < 5; c++) begin
                px   = m_bank[disp_front][ri * 5 + c];
                r[c] = slot < int'(px[11:8]);
                g[c] = slot < int'(px[7:4]);
                b[c] = slot < int'(px[3:0]);
            end
        end
        return {rw, r, g, b};
    endfunction

    task automatic start_scan;
        enable = 1'b1;
        tick;
        tick;
    endtask

    task automatic stop_scan;
        enable = 1'b0;
        tick;
        tick;
    endtask

    // Scans from phase 0, optionally with random writes and one swap request.
    task automatic test_scan(input int cycles, input int req_at, input bit do_wr);
        bit          ack_exp, err_exp, swap_now, wr;
        int          p;
        logic [19:0] e;
        logic [4:0]  a;
        logic [11:0] d;
        ack_exp = 1'b0;
        err_exp = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            p = i % FL;
            if (p == 0) disp_front = m_front;
            e = exp_disp(p);
            n_tests++;
            if ({row, col_r, col_g, col_b} !== e || frame_start !== (p == 0)) begin
                n_fail++;
                $display("FAIL scan_disp i=%0d p=%0d got row/r/g/b=%h fs=%b exp=%h fs=%b",
                         i, p, {row, col_r, col_g, col_b}, frame_start, e, (p == 0));
            end
            n_tests++;
            if (bus.swap_ack !== ack_exp || bus.wr_ready !== !m_pending ||
                bus.wr_err !== err_exp) begin
                n_fail++;
                $display("FAIL scan_hs i=%0d p=%0d got ack/rdy/err=%b%b%b exp=%b%b%b", i, p,
                         bus.swap_ack, bus.wr_ready, bus.wr_err, ack_exp, !m_pending, err_exp);
            end
            wr = do_wr && ($urandom_range(3) == 0);
            a  = 5'($urandom_range(31));
            d  = 12'($urandom);
            bus.wr_valid = wr;
            bus.wr_addr  = a;
            bus.wr_data  = d;
            bus.swap_req = (i == req_at);
            err_exp = 1'b0;
            if (wr && !m_pending) begin
                if (a < 5'd25) m_bank[1 - m_front][a] = d;
                else err_exp = 1'b1;
            end
            swap_now = m_pending && (p == FL - 2);
            ack_exp  = swap_now;
            if (swap_now) begin
                m_front   = 1 - m_front;
                m_pending = 1'b0;
            end else if (i == req_at) begin
                m_pending = 1'b1;
            end
            tick;
        end
        bus.wr_valid = 1'b0;
        bus.swap_req = 1'b0;
    endtask

    task automatic test_reset;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
        #1 rst_n = 1'b0;
        #10;
        n_tests++;
        if ({row, col_r, col_g, col_b, frame_start, bus.wr_ready, bus.wr_err,
             bus.swap_ack} !== '0) begin
            n_fail++;
            $display("FAIL reset_init got row=%b rdy=%b ack=%b exp all zero",
                     row, bus.wr_ready, bus.swap_ack);
        end
        rst_n = 1'b1;
        tick;
        n_tests++;
        if (bus.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b exp 1", bus.wr_ready);
        end
        // Reset in the middle of a scan with a swap pending.
        enable = 1'b1;
        repeat (40) tick;
        bus.swap_req = 1'b1;
        tick;
        bus.swap_req = 1'b0;
        tick;
        n_tests++;
        if (bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending_ready got %b exp 0", bus.wr_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({row, col_r, col_g, col_b, frame_start, bus.wr_ready, bus.wr_err,
             bus.swap_ack} !== '0) begin
            n_fail++;
            $display("FAIL reset_async got row=%b r=%b rdy=%b exp all zero",
                     row, col_r, bus.wr_ready);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (bus.swap_ack !== 1'b0 || row !== 5'b0 || bus.wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_after i=%0d got ack=%b row=%b rdy=%b exp 0/0/1",
                         i, bus.swap_ack, row, bus.wr_ready);
            end
            tick;
        end
        model_clear();
    endtask

    task automatic test_double_buffer;
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 12'hF00;
        tick;
        bus.wr_valid = 1'b0;
        m_bank[1 - m_front][7] = 12'hF00;
        enable = 1'b1;
        tick;
        n_tests++;
        if (row !== 5'b0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL db_startup got row=%b fs=%b exp 0/0", row, frame_start);
        end
        tick;
        test_scan(2 * FL + 10, 3, 1'b0);
        stop_scan();
    endtask

    task automatic disabled_swap;
        bus.swap_req = 1'b1;
        tick;
        bus.swap_req = 1'b0;
        m_front = 1 - m_front;
        n_tests++;
        if (bus.swap_ack !== 1'b1 || bus.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_swap_ack got ack=%b rdy=%b exp 1/1", bus.swap_ack, bus.wr_ready);
        end
        tick;
        n_tests++;
        if (bus.swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_swap_once got %b exp 0", bus.swap_ack);
        end
    endtask

    task automatic test_pwm_duty;
        int          cnt [3];
        logic [11:0] vals [3];
        vals[0] = 12'h001; vals[1] = 12'h008; vals[2] = 12'h000;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 5'(i); bus.wr_data = vals[i];
            tick;
            m_bank[1 - m_front][i] = vals[i];
        end
        bus.wr_valid = 1'b0;
        disabled_swap();
        start_scan();
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        for (int i = 0; i < RowLen; i++) begin
            for (int c = 0; c < 3; c++) cnt[c] += int'(col_b[c]);
            tick;
        end
        n_tests++;
        if (cnt[0] !== 2 || cnt[1] !== 16 || cnt[2] !== 0) begin
            n_fail++;
            $display("FAIL pwm_duty got %0d/%0d/%0d exp 2/16/0", cnt[0], cnt[1], cnt[2]);
        end
        stop_scan();
    endtask

    task automatic test_bad_addr;
        logic [4:0] bad [2];
        bad[0] = 5'd25; bad[1] = 5'd31;
        for (int k = 0; k < 2; k++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = bad[k]; bus.wr_data = 12'($urandom);
            tick;
            bus.wr_valid = 1'b0;
            n_tests++;
            if (bus.wr_err !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_addr_err addr=%0d got %b exp 1", bad[k], bus.wr_err);
            end
            tick;
            n_tests++;
            if (bus.wr_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_addr_pulse addr=%0d got %b exp 0", bad[k], bus.wr_err);
            end
        end
        disabled_swap();
        start_scan();
        test_scan(FL + 5, -1, 1'b0);
        stop_scan();
    endtask

    task automatic test_collision;
        logic [4:0]  a;
        logic [11:0] d;
        a = 5'($urandom_range(24));
        d = 12'($urandom) | 12'h111;
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        m_bank[1 - m_front][a] = d;
        disabled_swap();
        bus.wr_valid = 1'b0;
        start_scan();
        test_scan(FL + 4, -1, 1'b0);
        stop_scan();
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            start_scan();
            test_scan(2 * FL + 7, $urandom_range(FL - 3), 1'b1);
            stop_scan();
        end
    endtask

    task automatic test_frame_period;
        int cnt;
        start_scan();
        n_tests++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL period_first got %b exp 1", frame_start);
        end
        for (int k = 0; k < 2; k++) begin
            tick;
            cnt = 1;
            while (frame_start !== 1'b1 && cnt < 4 * FL) begin
                tick;
                cnt++;
            end
            n_tests++;
            if (cnt !== FL) begin
                n_fail++;
                $display("FAIL period k=%0d got %0d exp %0d", k, cnt, FL);
            end
        end
        stop_scan();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_double_buffer();
        test_pwm_duty();
        test_bad_addr();
        test_collision();
        test_random();
        test_frame_period();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
